keypad_scan_fifo: RTL and testbench

Parametrised matrix-keypad controller: scans a ROWS×COLS active-low key matrix, debounces every key individually, and queues press/release events in a FIFO readable over the peripheral register bus. It replaces the fixed 4×4 single-code keyboard peripheral. It adds multi-key tracking, release events, overflow reporting and an interrupt. It sits on the same memory-mapped peripheral bus as the other I/O blocks.

---
 rtl/keypad_scan_fifo_if.sv | 25 ++
 rtl/keypad_scan_fifo.sv | 240 ++++++++++++++++++++++++
 tb/tb_keypad_scan_fifo.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_fifo_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | keypad_scan_fifo_if : register-bus bundle for the keypad scanner        |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
interface keypad_scan_fifo_if;
   logic [7:0]  addrIn;
   logic [7:0]  addrOut;
   logic [3:0]  sizeDecode;
   logic [31:0] dataIn;
   logic        readEn;
   logic [31:0] dataOut;
   logic        irq;

   modport master (
      output addrIn, addrOut, sizeDecode, dataIn, readEn,
      input  dataOut, irq
   );

   modport slave (
      input  addrIn, addrOut, sizeDecode, dataIn, readEn,
      output dataOut, irq
   );
endinterface
`default_nettype wire

// File: rtl/keypad_scan_fifo.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | keypad_scan_fifo : scanned key matrix, per-key debounce, event FIFO     |
// | Optional auto-repeat under KEYPAD_AUTOREPEAT_EN.  Revision 1.0          |
// +-------------------------------------------------------------------------+
module keypad_scan_fifo #(
   parameter int ROWS         = 4,
   parameter int COLS         = 4,
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE     = 4,
   parameter int FIFO_DEPTH   = 8,
   parameter int REPEAT_DELAY = 30,
   parameter int REPEAT_RATE  = 8
) (
   input  wire logic             clk,
   input  wire logic             rst,
   keypad_scan_fifo_if.slave     bus,
   input  wire logic [COLS-1:0]  COL,
   output logic      [ROWS-1:0]  ROW
);
   localparam int KEYS  = ROWS * COLS;
   localparam int KW    = $clog2(KEYS);
   localparam int RW    = $clog2(ROWS);
   localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int DW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CNT_W = AW + 1;

   localparam logic [0:0] ST_OFF  = 1'b0;
   localparam logic [0:0] ST_SCAN = 1'b1;

   logic [0:0]      state, state_next;
   logic            en, irq_en;
   logic [RW-1:0]   row_idx;
   logic [DW-1:0]   div;
   logic [COLS-1:0] row_buf;
   logic            walking;
   logic [RW-1:0]   walk_row;
   logic [CW-1:0]   walk_col;
   logic [KEYS-1:0] stable;
   logic [BW-1:0]   cnt [KEYS];
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic            ovf;
   logic [31:0]     data_out_q;
   logic            irq_q;

   logic            ctrl_wr, clr, empty, full, pop, push_req, push_ok;
   logic            window_end, raw, diff, toggle;
   logic [6:0]      keycode;
   logic [KW-1:0]   kidx;
   logic [7:0]      push_data;
   logic [31:0]     rd_data;
   logic            unused_bits;

   assign ctrl_wr = (|bus.sizeDecode) && (bus.addrIn[3:2] == 2'd0);
   assign clr     = ctrl_wr && bus.dataIn[2];
   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(FIFO_DEPTH));
   assign pop     = bus.readEn && (bus.addrOut[3:2] == 2'd2) && !empty;

   assign unused_bits = ^{bus.addrIn[7:4], bus.addrIn[1:0], bus.addrOut[7:4],
                          bus.addrOut[1:0], bus.dataIn[31:3]};

   always_ff @(posedge clk) begin
      if (rst) begin
         en     <= 1'b0;
         irq_en <= 1'b0;
      end else if (ctrl_wr) begin
         en     <= bus.dataIn[0];
         irq_en <= bus.dataIn[1];
      end
   end

   // Scan FSM: state register / next state / row drive
   always_ff @(posedge clk) begin
      if (rst) state <= ST_OFF;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_OFF:  if (en)  state_next = ST_SCAN;
         ST_SCAN: if (!en) state_next = ST_OFF;
         default: state_next = ST_OFF;
      endcase
   end

   always_comb begin
      ROW = '1;
      if (state == ST_SCAN) ROW[row_idx] = 1'b0;
   end

   assign window_end = (state == ST_SCAN) && (div == DW'(SCAN_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst || state == ST_OFF) begin
         row_idx <= '0;
         div     <= '0;
      end else if (window_end) begin
         div     <= '0;
         row_idx <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
      end else begin
         div     <= div + 1'b1;
      end
   end

   // Row sample at the end of each window, then one key per cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         row_buf  <= '1;
         walking  <= 1'b0;
         walk_row <= '0;
         walk_col <= '0;
      end else if (state == ST_OFF) begin
         walking  <= 1'b0;
      end else if (window_end) begin
         row_buf  <= COL;
         walking  <= 1'b1;
         walk_row <= row_idx;
         walk_col <= '0;
      end else if (walking) begin
         walk_col <= walk_col + 1'b1;
         if (walk_col == CW'(COLS - 1)) walking <= 1'b0;
      end
   end

   assign keycode = 7'(int'(walk_row) * COLS + int'(walk_col));
   assign kidx    = keycode[KW-1:0];
   assign raw     = ~row_buf[walk_col];
   assign diff    = (raw != stable[kidx]);
   assign toggle  = walking && diff && (cnt[kidx] == BW'(DEBOUNCE - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         stable <= '0;
         for (int k = 0; k < KEYS; k++) cnt[k] <= '0;
      end else if (walking) begin
         if (!diff) begin
            cnt[kidx] <= '0;
         end else if (toggle) begin
            cnt[kidx]    <= '0;
            stable[kidx] <= raw;
         end else begin
            cnt[kidx] <= cnt[kidx] + 1'b1;
         end
      end
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   // Repeat ticks land in the last cycle of a frame, when the walker is idle
   logic        rep_active, rep_first, rep_due, frame_end;
   logic [6:0]  rep_key;
   logic [15:0] rep_cnt;

   assign frame_end = window_end && (row_idx == RW'(ROWS - 1));
   assign rep_due   = rep_active && frame_end &&
                      (rep_cnt == (rep_first ? 16'(REPEAT_DELAY - 1) : 16'(REPEAT_RATE - 1)));

   always_ff @(posedge clk) begin
      if (rst || state == ST_OFF || !en) begin
         rep_active <= 1'b0;
         rep_first  <= 1'b1;
         rep_cnt    <= '0;
         rep_key    <= '0;
      end else if (toggle && raw) begin
         rep_active <= 1'b1;
         rep_first  <= 1'b1;
         rep_cnt    <= '0;
         rep_key    <= keycode;
      end else if (toggle && !raw && keycode == rep_key) begin
         rep_active <= 1'b0;
      end else if (rep_due) begin
         rep_first  <= 1'b0;
         rep_cnt    <= '0;
      end else if (rep_active && frame_end) begin
         rep_cnt    <= rep_cnt + 1'b1;
      end
   end

   assign push_req  = toggle || rep_due;
   assign push_data = toggle ? {raw, keycode} : {1'b1, rep_key};
`else
   assign push_req  = toggle;
   assign push_data = {raw, keycode};
`endif

   // A pop in the same cycle frees the slot, so a full FIFO still accepts
   assign push_ok = push_req && (!full || pop);

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push_req && !push_ok) ovf <= 1'b1;
      end
   end

   always_comb begin
      rd_data = '0;
      case (bus.addrOut[3:2])
         2'd0: rd_data = {30'd0, irq_en, en};
         2'd1: rd_data = {21'd0, ovf, full, empty, 8'(count)};
         2'd2: rd_data = empty ? 32'hFFFF_FFFF : {1'b1, 23'd0, mem[rd_ptr]};
         2'd3: rd_data = 32'(stable);
         default: rd_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_out_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         if (bus.readEn) data_out_q <= rd_data;
         irq_q <= irq_en && !empty;
      end
   end

   assign bus.dataOut = data_out_q;
   assign bus.irq     = irq_q;
endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_fifo.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_keypad_scan_fifo : directed bench for keypad_scan_fifo               |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_keypad_scan_fifo;
   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int FRAME = 4 * 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [COLS-1:0] col;
   logic [ROWS-1:0] row;
   logic [15:0]     keys;
   int              checks = 0;
   int              errors = 0;

   keypad_scan_fifo_if bus();

   keypad_scan_fifo #(
      .ROWS(4), .COLS(4), .SCAN_DIV(8), .DEBOUNCE(2), .FIFO_DEPTH(4),
      .REPEAT_DELAY(30), .REPEAT_RATE(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave),
      .COL (col),
      .ROW (row)
   );

   always #5 clk = ~clk;

   // Key matrix: a held key pulls its column low while its row is driven
   always_comb begin
      col = '1;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (!row[r] && keys[r*COLS + c]) col[c] = 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_reg(input logic [7:0] addr, input logic [31:0] data);
      bus.addrIn     = addr;
      bus.dataIn     = data;
      bus.sizeDecode = 4'hF;
      @(negedge clk);
      bus.sizeDecode = 4'h0;
   endtask

   task automatic read_check(input string tag, input logic [7:0] addr, input logic [31:0] exp);
      bus.addrOut = addr;
      bus.readEn  = 1'b1;
      @(negedge clk);
      bus.readEn  = 1'b0;
      check(tag, bus.dataOut, exp);
   endtask

   // Returns at the first negedge of a fresh window driving the target row
   task automatic wait_row_start(input logic [ROWS-1:0] target);
      int n = 0;
      while (row === target && n < 200) begin @(negedge clk); n++; end
      while (row !== target && n < 400) begin @(negedge clk); n++; end
      check("wait_row", 32'(row), 32'(target));
   endtask

   initial begin
      rst            = 1'b1;
      keys           = '0;
      bus.addrIn     = '0;
      bus.addrOut    = '0;
      bus.sizeDecode = '0;
      bus.dataIn     = '0;
      bus.readEn     = 1'b0;
      cycles(3);
      check("rst_row", 32'(row), 32'hF);
      check("rst_dout", bus.dataOut, 32'h0);
      check("rst_irq", 32'(bus.irq), 32'h0);
      rst = 1'b0;
      read_check("rst_ctrl", 8'h00, 32'h0);
      read_check("rst_status", 8'h04, 32'h100);
      read_check("rst_keymap", 8'h0C, 32'h0);
      read_check("rst_event", 8'h08, 32'hFFFF_FFFF);

      // Press and release keycode 6
      write_reg(8'h00, 32'h1);
      keys[6] = 1'b1;
      cycles(6 * FRAME);
      read_check("pr_keymap", 8'h0C, 32'h40);
      keys[6] = 1'b0;
      cycles(4 * FRAME);
      check("pr_irq_off", 32'(bus.irq), 32'h0);
      read_check("pr_status", 8'h04, 32'h2);
      read_check("pr_ev_press", 8'h08, 32'h8000_0086);
      read_check("pr_ev_release", 8'h08, 32'h8000_0006);
      read_check("pr_ev_empty", 8'h08, 32'hFFFF_FFFF);

      // Bounce on key 0, then hold
      for (int i = 0; i < 5; i++) begin
         keys[0] = (i % 2 == 0);
         cycles(FRAME);
      end
      read_check("bn_quiet", 8'h04, 32'h100);
      cycles(3 * FRAME);
      read_check("bn_status", 8'h04, 32'h1);
      read_check("bn_ev", 8'h08, 32'h8000_0080);
      read_check("bn_ev_empty", 8'h08, 32'hFFFF_FFFF);
      keys[0] = 1'b0;
      cycles(3 * FRAME);
      read_check("bn_ev_rel", 8'h08, 32'h8000_0000);

      // IRQ timing: key 5 pressed at the start of a row-1 window
      write_reg(8'h00, 32'h3);
      wait_row_start(4'b1101);
      keys[5] = 1'b1;
      cycles(8);
      check("irq_row_adv", 32'(row), 32'hB);
      cycles(34);
      check("irq_pre", 32'(bus.irq), 32'h0);
      cycles(1);
      check("irq_rise", 32'(bus.irq), 32'h1);
      read_check("irq_ev", 8'h08, 32'h8000_0085);
      check("irq_hold", 32'(bus.irq), 32'h1);
      cycles(1);
      check("irq_fall", 32'(bus.irq), 32'h0);
      keys[5] = 1'b0;
      cycles(3 * FRAME);
      check("irq_rel", 32'(bus.irq), 32'h1);
      write_reg(8'h00, 32'h7);
      read_check("clr_ctrl", 8'h00, 32'h3);
      read_check("clr_status", 8'h04, 32'h100);
      cycles(1);
      check("clr_irq", 32'(bus.irq), 32'h0);

      // Overflow: five presses in one frame, four slots
      write_reg(8'h00, 32'h1);
      wait_row_start(4'b1110);
      keys = 16'h0227;
      cycles(3 * FRAME);
      read_check("ov_status", 8'h04, 32'h604);
      read_check("ov_keymap", 8'h0C, 32'h227);
      read_check("ov_ev0", 8'h08, 32'h8000_0080);
      read_check("ov_ev1", 8'h08, 32'h8000_0081);
      read_check("ov_ev2", 8'h08, 32'h8000_0082);
      read_check("ov_ev3", 8'h08, 32'h8000_0085);
      read_check("ov_drained", 8'h04, 32'h500);
      write_reg(8'h00, 32'h5);
      read_check("ov_clr", 8'h04, 32'h100);

      // Reset while row 2 is driven with keys held
      write_reg(8'h00, 32'h3);
      wait_row_start(4'b1011);
      cycles(2);
      rst = 1'b1;
      cycles(1);
      check("mr_row", 32'(row), 32'hF);
      check("mr_irq", 32'(bus.irq), 32'h0);
      check("mr_dout", bus.dataOut, 32'h0);
      rst = 1'b0;
      read_check("mr_ctrl", 8'h00, 32'h0);
      read_check("mr_keymap", 8'h0C, 32'h0);
      read_check("mr_status", 8'h04, 32'h100);
      keys = '0;
      cycles(FRAME);

      // Disable while key 6 is held
      write_reg(8'h00, 32'h1);
      keys[6] = 1'b1;
      cycles(3 * FRAME);
      read_check("ds_keymap", 8'h0C, 32'h40);
      read_check("ds_ev", 8'h08, 32'h8000_0086);
      write_reg(8'h00, 32'h0);
      cycles(1);
      check("ds_row", 32'(row), 32'hF);
      keys[6] = 1'b0;
      cycles(3 * FRAME);
      check("ds_row_idle", 32'(row), 32'hF);
      read_check("ds_status", 8'h04, 32'h100);
      read_check("ds_keymap_kept", 8'h0C, 32'h40);
      write_reg(8'h0C, 32'hFFFF_FFFF);
      write_reg(8'h04, 32'hFFFF_FFFF);
      read_check("ro_keymap", 8'h0C, 32'h40);
      read_check("ro_status", 8'h04, 32'h100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
